// File: rtl/fetch_queue_if.sv
// Fetch-queue bus: redirect from execute, instruction memory port and decode handshake.
// The fetch_queue connects through the master modport; the surrounding pipeline uses slave.
interface fetch_queue_if #(
  parameter int XLEN  = 32,
  parameter int DEPTH = 4
);
  logic                   redirect_valid;
  logic [XLEN-1:0]        redirect_pc;
  logic                   imem_enable;
  logic [XLEN-1:0]        imem_address;
  logic [XLEN-1:0]        imem_data;
  logic                   d_ready;
  logic                   d_valid;
  logic [XLEN-1:0]        d_instr;
  logic [XLEN-1:0]        d_pc;
  logic [$clog2(DEPTH):0] occupancy;

  modport master (
    input  redirect_valid, redirect_pc, imem_data, d_ready,
    output imem_enable, imem_address, d_valid, d_instr, d_pc, occupancy
  );

  modport slave (
    output redirect_valid, redirect_pc, imem_data, d_ready,
    input  imem_enable, imem_address, d_valid, d_instr, d_pc, occupancy
  );
endinterface

// File: rtl/fetch_queue.sv
// Instruction fetch queue: issues sequential imem reads, buffers responses in order for decode.
// Optional macro FETCH_QUEUE_BYPASS_EN shows a response to an empty queue directly to decode.
module fetch_queue #(
  parameter int              XLEN     = 32,
  parameter int              DEPTH    = 4,
  parameter logic [XLEN-1:0] RESET_PC = 32'h01000000
) (
  input logic           clock,
  input logic           reset,
  fetch_queue_if.master bus
);
  localparam int              PW      = $clog2(DEPTH);
  localparam int              CW      = PW + 1;
  localparam logic [CW-1:0]   DEPTH_C = CW'(DEPTH);
  localparam logic [XLEN-1:0] NOP     = XLEN'(32'h00000013);

  logic [XLEN-1:0] fetch_pc_q;
  logic            inflight_q;
  logic [XLEN-1:0] inflight_pc_q;
  logic [PW-1:0]   rd_ptr_q;
  logic [PW-1:0]   wr_ptr_q;
  logic [CW-1:0]   count_q;
  logic [CW-1:0]   count_d;
  logic [XLEN-1:0] instr_mem_q [DEPTH];
  logic [XLEN-1:0] pc_mem_q    [DEPTH];

  logic credit_ok;
  logic issue;
  logic head_valid;
  logic bypass_hit;
  logic pop;
  logic push;

  // count + inflight never exceeds DEPTH, so the sum fits in CW bits
  assign credit_ok  = (count_q + CW'(inflight_q)) < DEPTH_C;
  assign issue      = !reset && !bus.redirect_valid && credit_ok;
  assign head_valid = (count_q != '0);

`ifdef FETCH_QUEUE_BYPASS_EN
  assign bypass_hit = inflight_q && !head_valid;
`else
  assign bypass_hit = 1'b0;
`endif

  assign pop     = head_valid && bus.d_ready && !bus.redirect_valid;
  assign push    = inflight_q && !bus.redirect_valid && !(bypass_hit && bus.d_ready);
  assign count_d = count_q + CW'(push) - CW'(pop);

  assign bus.imem_enable  = issue;
  assign bus.imem_address = fetch_pc_q;
  assign bus.occupancy    = count_q;

`ifdef FETCH_QUEUE_BYPASS_EN
  always_comb begin
    bus.d_valid = 1'b0;
    bus.d_instr = NOP;
    bus.d_pc    = '0;
    if (head_valid) begin
      bus.d_valid = 1'b1;
      bus.d_instr = instr_mem_q[rd_ptr_q];
      bus.d_pc    = pc_mem_q[rd_ptr_q];
    end else if (bypass_hit) begin
      bus.d_valid = 1'b1;
      bus.d_instr = bus.imem_data;
      bus.d_pc    = inflight_pc_q;
    end
  end
`else
  assign bus.d_valid = head_valid;
  assign bus.d_instr = head_valid ? instr_mem_q[rd_ptr_q] : NOP;
  assign bus.d_pc    = head_valid ? pc_mem_q[rd_ptr_q] : '0;
`endif

  // Redirect dominates: the queue is flushed and any response arriving this cycle is dropped.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      fetch_pc_q    <= RESET_PC;
      inflight_q    <= 1'b0;
      inflight_pc_q <= '0;
      rd_ptr_q      <= '0;
      wr_ptr_q      <= '0;
      count_q       <= '0;
    end else if (bus.redirect_valid) begin
      fetch_pc_q <= bus.redirect_pc & ~XLEN'(3);
      inflight_q <= 1'b0;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      count_q    <= '0;
    end else begin
      inflight_q <= issue;
      if (issue) begin
        inflight_pc_q <= fetch_pc_q;
        fetch_pc_q    <= fetch_pc_q + XLEN'(4);
      end
      if (push) wr_ptr_q <= wr_ptr_q + PW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PW'(1);
      count_q <= count_d;
    end
  end

  always_ff @(posedge clock) begin
    if (push) begin
      instr_mem_q[wr_ptr_q] <= bus.imem_data;
      pc_mem_q[wr_ptr_q]    <= inflight_pc_q;
    end
  end
endmodule

// File: tb/tb_fetch_queue.sv
// Bench for fetch_queue: DEPTH 2/4/8 instances checked each cycle against a queue-level model.
module tb_fetch_queue;
  localparam logic [31:0] RST_PC = 32'h01000000;
  localparam logic [31:0] NOP    = 32'h00000013;
  localparam int          NI     = 3;
`ifdef FETCH_QUEUE_BYPASS_EN
  localparam bit BYP = 1'b1;
  localparam int FDV = 2;
`else
  localparam bit BYP = 1'b0;
  localparam int FDV = 3;
`endif

  int depth_of [NI] = '{2, 4, 8};

  logic        clk = 1'b0;
  logic        rst;
  logic        redir [NI];
  logic [31:0] rpc   [NI];
  logic        rdy   [NI];
  logic [31:0] idata [NI];

  wire        en_w   [NI];
  wire [31:0] addr_w [NI];
  wire        dv_w   [NI];
  wire [31:0] di_w   [NI];
  wire [31:0] dpc_w  [NI];
  wire [7:0]  occ_w  [NI];

  always #5 clk = ~clk;

  for (genvar g = 0; g < NI; g++) begin : g_dut
    localparam int D = (g == 0) ? 2 : (g == 1) ? 4 : 8;
    fetch_queue_if #(.XLEN(32), .DEPTH(D)) ifc ();
    assign ifc.redirect_valid = redir[g];
    assign ifc.redirect_pc    = rpc[g];
    assign ifc.imem_data      = idata[g];
    assign ifc.d_ready        = rdy[g];
    assign en_w[g]   = ifc.imem_enable;
    assign addr_w[g] = ifc.imem_address;
    assign dv_w[g]   = ifc.d_valid;
    assign di_w[g]   = ifc.d_instr;
    assign dpc_w[g]  = ifc.d_pc;
    assign occ_w[g]  = 8'(ifc.occupancy);
    fetch_queue #(.XLEN(32), .DEPTH(D), .RESET_PC(RST_PC)) dut (
      .clock (clk),
      .reset (rst),
      .bus   (ifc.master)
    );
  end

  // model: next fetch PC, one outstanding request, FIFO of PCs awaiting decode
  logic [31:0] m_fpc  [NI];
  bit          m_infl [NI];
  logic [31:0] m_ipc  [NI];
  logic [31:0] m_q    [NI][$];

  bit          s_en   [NI];
  logic [31:0] s_addr [NI];
  bit          s_dv   [NI];
  logic [31:0] s_di   [NI];
  logic [31:0] s_dpc  [NI];
  logic [7:0]  s_occ  [NI];

  int n_assert;
  int n_fail;
  int cyc;

  function automatic logic [31:0] mem_word(logic [31:0] a);
    return (a * 32'h9E3779B1) ^ 32'h5A5A5A5A;
  endfunction

  task automatic chk(string name, int k, logic [31:0] got, logic [31:0] exp);
    n_assert++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s inst=%0d cyc=%0d got=%h exp=%h", name, k, cyc, got, exp);
    end
  endtask

  task automatic check_and_step(int k);
    bit          e_en, e_dv, byp, take;
    logic [31:0] e_addr, e_di, e_dpc;
    int          e_occ, sz;
    s_en[k]   = en_w[k];
    s_addr[k] = addr_w[k];
    s_dv[k]   = dv_w[k];
    s_di[k]   = di_w[k];
    s_dpc[k]  = dpc_w[k];
    s_occ[k]  = occ_w[k];
    sz    = m_q[k].size();
    byp   = 1'b0;
    e_dv  = 1'b0;
    e_di  = NOP;
    e_dpc = 32'h0;
    if (rst) begin
      e_en = 1'b0; e_addr = RST_PC; e_occ = 0;
    end else begin
      e_occ  = sz;
      e_addr = m_fpc[k];
      e_en   = !redir[k] && (sz + int'(m_infl[k]) < depth_of[k]);
      byp    = BYP && (sz == 0) && m_infl[k];
      if (byp) begin
        e_dv = 1'b1; e_dpc = m_ipc[k]; e_di = mem_word(m_ipc[k]);
      end else if (sz > 0) begin
        e_dv = 1'b1; e_dpc = m_q[k][0]; e_di = mem_word(m_q[k][0]);
      end
    end
    chk("imem_enable",  k, 32'(s_en[k]), 32'(e_en));
    chk("imem_address", k, s_addr[k], e_addr);
    chk("d_valid",      k, 32'(s_dv[k]), 32'(e_dv));
    chk("d_instr",      k, s_di[k], e_di);
    chk("d_pc",         k, s_dpc[k], e_dpc);
    chk("occupancy",    k, 32'(s_occ[k]), 32'(e_occ));
    if (rst) begin
      m_fpc[k] = RST_PC; m_infl[k] = 1'b0; m_q[k].delete();
    end else if (redir[k]) begin
      m_q[k].delete(); m_infl[k] = 1'b0; m_fpc[k] = rpc[k] & ~32'h3;
    end else begin
      take = e_dv && rdy[k];
      if (take && !byp) void'(m_q[k].pop_front());
      if (m_infl[k] && !(byp && take)) m_q[k].push_back(m_ipc[k]);
      m_infl[k] = e_en;
      if (e_en) begin
        m_ipc[k] = m_fpc[k];
        m_fpc[k] = m_fpc[k] + 32'd4;
      end
    end
  endtask

  // inputs change at posedge+1; outputs sampled and compared at negedge
  task automatic cycle();
    @(negedge clk);
    for (int k = 0; k < NI; k++) check_and_step(k);
    @(posedge clk);
    #1;
    for (int k = 0; k < NI; k++) idata[k] = s_en[k] ? mem_word(s_addr[k]) : $urandom;
    cyc++;
  endtask

  task automatic set_all(bit rv, logic [31:0] pc, bit rd);
    for (int k = 0; k < NI; k++) begin
      redir[k] = rv; rpc[k] = pc; rdy[k] = rd;
    end
  endtask

  task automatic wait_first_dv(string name, logic [31:0] exp_pc, int exp_wait);
    int waited = 0;
    bit seen = 1'b0;
    while (!seen && waited < 8) begin
      cycle();
      if (s_dv[1]) seen = 1'b1;
      else waited++;
    end
    chk({name, "_seen"}, 1, 32'(seen), 32'd1);
    chk({name, "_wait"}, 1, 32'(waited), 32'(exp_wait));
    chk({name, "_pc"},   1, s_dpc[1], exp_pc);
  endtask

  initial begin
    bit found;
    n_assert = 0; n_fail = 0; cyc = 0;
    rst = 1'b1;
    set_all(1'b0, 32'h0, 1'b1);
    for (int k = 0; k < NI; k++) begin
      idata[k] = $urandom;
      m_fpc[k] = RST_PC; m_infl[k] = 1'b0; m_ipc[k] = 32'h0;
    end
    #1;
    repeat (3) cycle();

    // sequential fetch after reset release
    rst = 1'b0;
    for (int c = 1; c <= 6; c++) begin
      cycle();
      chk("seq_en",   1, 32'(s_en[1]), 32'd1);
      chk("seq_addr", 1, s_addr[1], RST_PC + 32'(4 * (c - 1)));
      if (c < FDV)      chk("seq_dv_early", 1, 32'(s_dv[1]), 32'd0);
      if (c == FDV)     chk("seq_first_pc", 1, s_dpc[1], RST_PC);
      if (c == FDV + 1) chk("seq_second_pc", 1, s_dpc[1], RST_PC + 32'd4);
    end

    // decode stall saturates the DEPTH=4 queue
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    set_all(1'b0, 32'h0, 1'b0);
    repeat (10) cycle();
    chk("stall_occ",   1, 32'(s_occ[1]), 32'd4);
    chk("stall_en",    1, 32'(s_en[1]), 32'd0);
    chk("stall_pc",    1, s_dpc[1], RST_PC);
    chk("stall_instr", 1, s_di[1], mem_word(RST_PC));
    chk("stall_occ_d2", 0, 32'(s_occ[0]), 32'd2);

    // redirect with a request in flight
    set_all(1'b0, 32'h0, 1'b1);
    found = 1'b0;
    for (int i = 0; i < 10 && !found; i++) begin
      cycle();
      if (s_en[1]) found = 1'b1;
    end
    chk("redir_pre_issue", 1, 32'(found), 32'd1);
    set_all(1'b1, 32'h01000103, 1'b1);
    cycle();
    chk("redir_en_low", 1, 32'(s_en[1]), 32'd0);
    set_all(1'b0, 32'h0, 1'b1);
    cycle();
    chk("redir_occ",  1, 32'(s_occ[1]), 32'd0);
    chk("redir_en",   1, 32'(s_en[1]), 32'd1);
    chk("redir_addr", 1, s_addr[1], 32'h01000100);
    wait_first_dv("redir_dv", 32'h01000100, FDV - 2);

    // redirect coincident with a decode pop
    repeat (4) cycle();
    set_all(1'b1, 32'h02000000, 1'b1);
    cycle();
    chk("coinc_dv", 1, 32'(s_dv[1]), 32'd1);
    set_all(1'b0, 32'h0, 1'b1);
    cycle();
    chk("coinc_occ", 1, 32'(s_occ[1]), 32'd0);
    chk("coinc_dv_after", 1, 32'(s_dv[1]), 32'd0);
    chk("coinc_pc_after", 1, s_dpc[1], 32'h0);
    wait_first_dv("coinc_next", 32'h02000000, FDV - 2);

    // asynchronous reset mid-stream
    set_all(1'b0, 32'h0, 1'b0);
    found = 1'b0;
    for (int i = 0; i < 12 && !found; i++) begin
      cycle();
      if (s_occ[1] == 8'd3) found = 1'b1;
    end
    chk("mid_occ3", 1, 32'(found), 32'd1);
    rst = 1'b1;
    #1;
    chk("async_en",  1, 32'(en_w[1]), 32'd0);
    chk("async_dv",  1, 32'(dv_w[1]), 32'd0);
    chk("async_di",  1, di_w[1], NOP);
    chk("async_dpc", 1, dpc_w[1], 32'h0);
    chk("async_occ", 1, 32'(occ_w[1]), 32'd0);
    repeat (2) cycle();
    rst = 1'b0;
    set_all(1'b0, 32'h0, 1'b1);
    cycle();
    chk("restart_addr", 1, s_addr[1], RST_PC);
    chk("restart_en",   1, 32'(s_en[1]), 32'd1);
    wait_first_dv("restart_dv", RST_PC, FDV - 2);

    // randomized traffic on all depths
    for (int n = 0; n < 3000; n++) begin
      rst = ($urandom_range(0, 999) < 3);
      for (int k = 0; k < NI; k++) begin
        rdy[k]   = ($urandom_range(0, 99) < ((k == 0) ? 50 : 70));
        redir[k] = ($urandom_range(0, 99) < 3);
        rpc[k]   = $urandom;
      end
      cycle();
      for (int k = 0; k < NI; k++)
        chk("occ_bound", k, 32'(int'(s_occ[k]) <= depth_of[k]), 32'd1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
